// File: rtl/tls_pkg.sv
// Shared encodings for the two-approach phase scheduler: lamp codes and state codes.
package tls_pkg;

   localparam logic [2:0] LIGHT_G = 3'b100;
   localparam logic [2:0] LIGHT_Y = 3'b010;
   localparam logic [2:0] LIGHT_R = 3'b001;

   // Codes are fixed because they are exported on the debug phase port.
   typedef enum logic [2:0] {
      AG   = 3'd0,
      AY   = 3'd1,
      RR   = 3'd2,
      BG   = 3'd3,
      BY   = 3'd4,
      WALK = 3'd5
   } tls_state_t;

endpackage

// File: rtl/tls_phase_timer.sv
// Phase timer: counts timebase ticks within the current phase, clears on phase
// change, optionally saturates, and flags when a programmed duration is reached.
module tls_phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             sat_en,
   input  logic [CNT_W-1:0] sat_val,
   input  logic [CNT_W-1:0] cmp_val,
   output logic [CNT_W-1:0] count,
   output logic             expire
);

   // Tick counter: cleared on phase change, holds once the saturation value is reached.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && !(sat_en && (count == sat_val))) begin
         count <= count + CNT_W'(1);
      end
   end

   // Expiry is only meaningful on a tick edge.
   always_comb begin
      expire = en && (count == cmp_val);
   end

endmodule

// File: rtl/tls_phase_scheduler.sv
// Two-approach intersection phase scheduler with demand-driven green arbitration,
// yellow and all-red clearance, and a latched pedestrian WALK phase.
module tls_phase_scheduler
   import tls_pkg::*;
#(
   parameter int unsigned GREEN_MIN = 4,
   parameter int unsigned GREEN_MAX = 10,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned WALK_T    = 3,
   parameter int unsigned CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       car_a,
   input  logic       car_b,
   input  logic       ped_req,
   output logic [2:0] LA,
   output logic [2:0] LB,
   output logic       walk,
   output logic [2:0] phase
);

   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

   tls_state_t       state, state_d;
   logic             next_dir, next_dir_d;
   logic             ped_pending, ped_pending_d;
   logic [CNT_W-1:0] timer;
   logic             expire;
   logic             in_green;
   logic [CNT_W-1:0] cmp_val;

   // Select the duration that ends the current phase; greens use the cap.
   always_comb begin
      in_green = (state == AG) || (state == BG);
      case (state)
         AY, BY:  cmp_val = YEL_LAST;
         RR:      cmp_val = RED_LAST;
         WALK:    cmp_val = WALK_LAST;
         default: cmp_val = GMAX_LAST;
      endcase
   end

   tls_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_d != state),
      .en      (tick),
      .sat_en  (in_green),
      .sat_val (GMAX_LAST),
      .cmp_val (cmp_val),
      .count   (timer),
      .expire  (expire)
   );

   // State, service direction and pedestrian latch registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RR;
         next_dir    <= 1'b0;
         ped_pending <= 1'b0;
      end else begin
         state       <= state_d;
         next_dir    <= next_dir_d;
         ped_pending <= ped_pending_d;
      end
   end

   // Next-state logic: green ends once min green has run, someone else is waiting,
   // and either own demand is gone or the cap is reached.
   always_comb begin
      state_d    = state;
      next_dir_d = next_dir;
      case (state)
         AG: if (tick && (timer >= GMIN_LAST) && (car_b || ped_pending) &&
                 (!car_a || (timer == GMAX_LAST)))
                state_d = AY;
         BG: if (tick && (timer >= GMIN_LAST) && (car_a || ped_pending) &&
                 (!car_b || (timer == GMAX_LAST)))
                state_d = BY;
         AY: if (expire) begin
                state_d    = RR;
                next_dir_d = 1'b1;
             end
         BY: if (expire) begin
                state_d    = RR;
                next_dir_d = 1'b0;
             end
         RR: if (expire) begin
                if (ped_pending)   state_d = WALK;
                else if (next_dir) state_d = BG;
                else               state_d = AG;
             end
         WALK: if (expire) state_d = next_dir ? BG : AG;
         default: state_d = RR;
      endcase
      // Entering WALK serves every request seen so far, including one on this edge.
      if ((state_d == WALK) && (state != WALK)) ped_pending_d = 1'b0;
      else                                      ped_pending_d = ped_pending | ped_req;
   end

   // Moore decode of lamp heads, walk indicator and debug phase.
   always_comb begin
      LA    = LIGHT_R;
      LB    = LIGHT_R;
      walk  = 1'b0;
      phase = state;
      case (state)
         AG:   LA = LIGHT_G;
         AY:   LA = LIGHT_Y;
         BG:   LB = LIGHT_G;
         BY:   LB = LIGHT_Y;
         WALK: walk = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tls_phase_scheduler.sv
// Self-checking bench for tls_phase_scheduler with a behavioural reference model.
module tb_tls_phase_scheduler;

   localparam int GMIN = 4, GMAX = 10, YEL = 2, RED = 1, WLK = 3;
   localparam int P_AG = 0, P_AY = 1, P_RR = 2, P_BG = 3, P_BY = 4, P_WALK = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1, tick = 1'b1, car_a = 1'b0, car_b = 1'b0, ped_req = 1'b0;
   logic [2:0] LA, LB, phase;
   logic       walk;
   logic [9:0] obs;

   int checks = 0;
   int errors = 0;

   // reference model: phase, ticks elapsed in phase (unbounded), direction, ped latch
   int m_st, m_el, m_dir, m_ped;
   int exp_q[$];

   tls_phase_scheduler #(
      .GREEN_MIN (GMIN), .GREEN_MAX (GMAX), .YELLOW_T (YEL),
      .ALLRED_T (RED), .WALK_T (WLK), .CNT_W (8)
   ) dut (
      .clk (clk), .rst (rst), .tick (tick), .car_a (car_a), .car_b (car_b),
      .ped_req (ped_req), .LA (LA), .LB (LB), .walk (walk), .phase (phase)
   );

   always #5 clk = ~clk;
   assign obs = {phase, LA, LB, walk};

   function automatic logic [6:0] lights_of(input int p);
      case (p)
         P_AG:   return 7'b100_001_0;
         P_AY:   return 7'b010_001_0;
         P_BG:   return 7'b001_100_0;
         P_BY:   return 7'b001_010_0;
         P_WALK: return 7'b001_001_1;
         default: return 7'b001_001_0;
      endcase
   endfunction

   function automatic logic [9:0] expect_of(input int p);
      return {3'(p), lights_of(p)};
   endfunction

   task automatic model_step();
      int nst, nd, np;
      if (rst) begin
         m_st = P_RR; m_el = 0; m_dir = 0; m_ped = 0;
         return;
      end
      nst = m_st; nd = m_dir;
      if (tick) begin
         case (m_st)
            P_AG: if (m_el >= GMIN-1 && (car_b || m_ped != 0) && (!car_a || m_el >= GMAX-1)) nst = P_AY;
            P_BG: if (m_el >= GMIN-1 && (car_a || m_ped != 0) && (!car_b || m_el >= GMAX-1)) nst = P_BY;
            P_AY: if (m_el == YEL-1) begin nst = P_RR; nd = 1; end
            P_BY: if (m_el == YEL-1) begin nst = P_RR; nd = 0; end
            P_RR: if (m_el == RED-1) nst = (m_ped != 0) ? P_WALK : (m_dir != 0 ? P_BG : P_AG);
            default: if (m_el == WLK-1) nst = (m_dir != 0) ? P_BG : P_AG;
         endcase
      end
      np = (nst == P_WALK && m_st != P_WALK) ? 0 : ((m_ped != 0 || ped_req) ? 1 : 0);
      if (nst != m_st) m_el = 0;
      else if (tick) m_el = m_el + 1;
      m_st = nst; m_dir = nd; m_ped = np;
   endtask

   // apply inputs for one clk edge; outputs are sampled 1 time unit after the edge
   task automatic step(input logic r, input logic t, input logic a, input logic b, input logic p);
      rst = r; tick = t; car_a = a; car_b = b; ped_req = p;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
   endtask

   task automatic push(input int p, input int d);
      repeat (d) exp_q.push_back(p);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 0, 0, 0);
         checks++;
         if (obs !== 10'b010_001_001_0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d got %b want %b", i, obs, 10'b010_001_001_0);
         end
      end
      step(0, 1, 0, 0, 0);
      checks++;
      if (obs !== 10'b000_100_001_0) begin
         errors++;
         $display("FAIL reset_release got %b want %b", obs, 10'b000_100_001_0);
      end
   endtask

   task automatic test_max_green();
      do_reset();
      exp_q.delete();
      push(P_AG, 10); push(P_AY, 2); push(P_RR, 1);
      push(P_BG, 10); push(P_BY, 2); push(P_RR, 1);
      push(P_AG, 10); push(P_AY, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         step(0, 1, 1, 1, 0);
         checks++;
         if (obs !== expect_of(exp_q[i])) begin
            errors++;
            $display("FAIL max_green cycle %0d got %b want %b", i, obs, expect_of(exp_q[i]));
         end
         checks++;
         if (LA !== 3'b001 && LB !== 3'b001) begin
            errors++;
            $display("FAIL max_green_conflict cycle %0d LA %b LB %b", i, LA, LB);
         end
      end
   endtask

   task automatic test_gap_out();
      do_reset();
      exp_q.delete();
      push(P_AG, 4); push(P_AY, 2); push(P_RR, 1); push(P_BG, 6);
      for (int i = 0; i < exp_q.size(); i++) begin
         step(0, 1, 0, 1, 0);
         checks++;
         if (obs !== expect_of(exp_q[i])) begin
            errors++;
            $display("FAIL gap_out cycle %0d got %b want %b", i, obs, expect_of(exp_q[i]));
         end
      end
   endtask

   task automatic test_rest();
      do_reset();
      for (int i = 0; i < 50; i++) begin
         step(0, 1, 0, 0, 0);
         checks++;
         if (LA !== 3'b100 || LB !== 3'b001) begin
            errors++;
            $display("FAIL rest_green cycle %0d got LA %b LB %b want 100 001", i, LA, LB);
         end
      end
      checks++;
      if (dut.u_timer.count !== 8'd9) begin
         errors++;
         $display("FAIL rest_timer got %0d want 9", dut.u_timer.count);
      end
      step(0, 1, 0, 1, 0);
      checks++;
      if (obs !== expect_of(P_AY)) begin
         errors++;
         $display("FAIL rest_wake got %b want %b", obs, expect_of(P_AY));
      end
   endtask

   task automatic test_ped();
      do_reset();
      exp_q.delete();
      push(P_AG, 4); push(P_AY, 2); push(P_RR, 1); push(P_WALK, 3);
      push(P_BG, 4); push(P_BY, 2); push(P_RR, 1); push(P_WALK, 3);
      push(P_AG, 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         step(0, 1, 0, 0, (i == 0 || i == 8) ? 1'b1 : 1'b0);
         checks++;
         if (obs !== expect_of(exp_q[i])) begin
            errors++;
            $display("FAIL ped cycle %0d got %b want %b", i, obs, expect_of(exp_q[i]));
         end
      end
   endtask

   task automatic test_sparse_tick();
      int run = 0, seen_runs = 0;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         step(0, (i % 4 == 0) ? 1'b1 : 1'b0, 1, 1, 0);
         checks++;
         if (obs !== expect_of(m_st)) begin
            errors++;
            $display("FAIL sparse cycle %0d got %b want %b", i, obs, expect_of(m_st));
         end
         if (phase == 3'(P_AY)) run++;
         else if (run != 0) begin
            seen_runs++;
            checks++;
            if (run != 4*YEL) begin
               errors++;
               $display("FAIL sparse_yellow_len got %0d want %0d", run, 4*YEL);
            end
            run = 0;
         end
      end
      checks++;
      if (seen_runs == 0) begin
         errors++;
         $display("FAIL sparse_yellow_seen got 0 runs want >0");
      end
   endtask

   task automatic test_reset_mid_walk();
      int n = 0;
      do_reset();
      step(0, 1, 0, 0, 1);
      while (phase !== 3'(P_WALK) && n < 30) begin
         step(0, 1, 0, 0, 0);
         n++;
      end
      checks++;
      if (phase !== 3'(P_WALK)) begin
         errors++;
         $display("FAIL walk_reach got phase %b want %b", phase, 3'(P_WALK));
      end
      step(0, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      checks++;
      if (obs !== 10'b010_001_001_0) begin
         errors++;
         $display("FAIL walk_reset got %b want %b", obs, 10'b010_001_001_0);
      end
      checks++;
      if (dut.ped_pending !== 1'b0) begin
         errors++;
         $display("FAIL walk_reset_ped got %b want 0", dut.ped_pending);
      end
   endtask

   task automatic test_random();
      logic a = 0, b = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) a = ~a;
         if ($urandom_range(0, 15) == 0) b = ~b;
         step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)), a, b,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
         checks++;
         if (obs !== expect_of(m_st)) begin
            errors++;
            $display("FAIL random cycle %0d got %b want %b", i, obs, expect_of(m_st));
         end
         checks++;
         if (LA !== 3'b001 && LB !== 3'b001) begin
            errors++;
            $display("FAIL random_conflict cycle %0d LA %b LB %b", i, LA, LB);
         end
      end
   endtask

   initial begin
      test_reset();
      test_max_green();
      test_gap_out();
      test_rest();
      test_ped();
      test_sparse_tick();
      test_reset_mid_walk();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
